// File: rtl/pipeid_sb_pkg.sv
// Shared definitions for the pipeid_sb operand/issue stage: width helpers
// and the forwarding-source encoding used by the operand muxes.
package pipeid_sb_pkg;

  // Register-number width for a register file of nreg entries.
  function automatic int aw_of(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  // Width of a countdown counter that must hold values 0..lat.
  function automatic int cnt_w(input int lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

  // Where a resolved operand came from.
  typedef enum logic [2:0] {
    FWD_QA   = 3'd0,  // register file read data
    FWD_EALU = 3'd1,  // E-stage ALU result
    FWD_MALU = 3'd2,  // M-stage ALU result
    FWD_MMO  = 3'd3,  // M-stage memory data
    FWD_WDI  = 3'd4,  // W-stage write data
    FWD_ZERO = 3'd5   // register 0
  } fwd_sel_e;

endpackage

// File: rtl/pipeid_sb_fwd.sv
// Single-operand forwarding mux with load-use hazard match.
// The E stage wins over M, M over W, W over the register file.
module pipeid_sb_fwd
  import pipeid_sb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int WBYP = 1
) (
  input  logic [AW-1:0]   src_i,
  input  logic            use_i,
  input  logic [XLEN-1:0] qd_i,
  input  logic [AW-1:0]   ern_i,
  input  logic            ewreg_i,
  input  logic            em2reg_i,
  input  logic [XLEN-1:0] ealu_i,
  input  logic [AW-1:0]   mrn_i,
  input  logic            mwreg_i,
  input  logic            mm2reg_i,
  input  logic [XLEN-1:0] malu_i,
  input  logic [XLEN-1:0] mmo_i,
  input  logic [AW-1:0]   wrn_i,
  input  logic            wwreg_i,
  input  logic [XLEN-1:0] wdi_i,
  output logic [XLEN-1:0] val_o,
  output logic            load_use_o
);

  fwd_sel_e sel;

  // Pick the youngest in-flight producer of this source register.
  always_comb begin
    sel = FWD_QA;
    if (src_i == '0)                                        sel = FWD_ZERO;
    else if (ewreg_i && !em2reg_i && (ern_i == src_i))      sel = FWD_EALU;
    else if (mwreg_i && (mrn_i == src_i))                   sel = mm2reg_i ? FWD_MMO : FWD_MALU;
    else if ((WBYP != 0) && wwreg_i && (wrn_i == src_i))    sel = FWD_WDI;
  end

  // Steer the selected source onto the operand.
  always_comb begin
    val_o = qd_i;
    unique case (sel)
      FWD_ZERO: val_o = '0;
      FWD_EALU: val_o = ealu_i;
      FWD_MALU: val_o = malu_i;
      FWD_MMO:  val_o = mmo_i;
      FWD_WDI:  val_o = wdi_i;
      default:  val_o = qd_i;
    endcase
  end

  // A load in E cannot forward yet: the reader must wait one cycle.
  always_comb begin
    load_use_o = use_i && ewreg_i && em2reg_i && (ern_i != '0) && (ern_i == src_i);
  end

endmodule

// File: rtl/pipeid_sb.sv
// Operand/issue stage: resolves operands through E/M/W bypasses, stalls on
// load-use, long-latency dependencies and a busy long unit, and registers
// issued work into the ID/EX stage.
//
// Handshake: an instruction in D (dvalid=1) is accepted on a rising edge
// exactly when wpcir=1; when wpcir=0 it must be held unchanged in D and a
// bubble (xvalid=0) enters EX instead. wpcir depends only on current inputs
// and scoreboard state.
module pipeid_sb
  import pipeid_sb_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int LONG_LAT = 4,
  parameter  int WBYP     = 1,
  localparam int AW       = aw_of(NREG)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            dvalid,
  input  logic [AW-1:0]   rs,
  input  logic [AW-1:0]   rt,
  input  logic            use_rs,
  input  logic            use_rt,
  input  logic [AW-1:0]   drn,
  input  logic            dwreg,
  input  logic            dm2reg,
  input  logic            dlong,
  input  logic [XLEN-1:0] qa,
  input  logic [XLEN-1:0] qb,
  input  logic [AW-1:0]   ern,
  input  logic [AW-1:0]   mrn,
  input  logic [AW-1:0]   wrn,
  input  logic            ewreg,
  input  logic            em2reg,
  input  logic            mwreg,
  input  logic            mm2reg,
  input  logic            wwreg,
  input  logic [XLEN-1:0] ealu,
  input  logic [XLEN-1:0] malu,
  input  logic [XLEN-1:0] mmo,
  input  logic [XLEN-1:0] wdi,
  output logic            wpcir,
  output logic            rsrtequ,
  output logic            xvalid,
  output logic            xwreg,
  output logic            xm2reg,
  output logic            xlong,
  output logic [XLEN-1:0] xa,
  output logic [XLEN-1:0] xb,
  output logic [AW-1:0]   xrn
);

  localparam int CW = cnt_w(LONG_LAT);
  localparam logic [CW-1:0] LAT_M1 = CW'(LONG_LAT - 1);

  logic [XLEN-1:0] a_val, b_val;
  logic            lu_a, lu_b;
  logic            sb_hit, struct_hit, stall, issue;

  logic [NREG-1:0][CW-1:0] pend_q, pend_d;
  logic [CW-1:0]           busy_q, busy_d;

  logic            xvalid_q, xvalid_d, xwreg_q, xwreg_d;
  logic            xm2reg_q, xm2reg_d, xlong_q, xlong_d;
  logic [XLEN-1:0] xa_q, xa_d, xb_q, xb_d;
  logic [AW-1:0]   xrn_q, xrn_d;

  pipeid_sb_fwd #(.XLEN(XLEN), .AW(AW), .WBYP(WBYP)) u_fwd_a (
    .src_i(rs), .use_i(use_rs), .qd_i(qa),
    .ern_i(ern), .ewreg_i(ewreg), .em2reg_i(em2reg), .ealu_i(ealu),
    .mrn_i(mrn), .mwreg_i(mwreg), .mm2reg_i(mm2reg), .malu_i(malu), .mmo_i(mmo),
    .wrn_i(wrn), .wwreg_i(wwreg), .wdi_i(wdi),
    .val_o(a_val), .load_use_o(lu_a)
  );

  pipeid_sb_fwd #(.XLEN(XLEN), .AW(AW), .WBYP(WBYP)) u_fwd_b (
    .src_i(rt), .use_i(use_rt), .qd_i(qb),
    .ern_i(ern), .ewreg_i(ewreg), .em2reg_i(em2reg), .ealu_i(ealu),
    .mrn_i(mrn), .mwreg_i(mwreg), .mm2reg_i(mm2reg), .malu_i(malu), .mmo_i(mmo),
    .wrn_i(wrn), .wwreg_i(wwreg), .wdi_i(wdi),
    .val_o(b_val), .load_use_o(lu_b)
  );

  // Hazard detection; pend[0] is never set, so register 0 never stalls.
  always_comb begin
    sb_hit     = (use_rs && (pend_q[rs] != '0)) ||
                 (use_rt && (pend_q[rt] != '0)) ||
                 (dwreg  && (pend_q[drn] != '0));
    struct_hit = dlong && (busy_q != '0);
    stall      = dvalid && (lu_a || lu_b || sb_hit || struct_hit);
    issue      = dvalid && !stall;
    wpcir      = !stall;
    rsrtequ    = (a_val == b_val);
  end

  // Countdown scoreboard: decrement toward zero, issue of a long op reloads.
  always_comb begin
    pend_d = '0;
    for (int r = 1; r < NREG; r++) begin
      pend_d[r] = (pend_q[r] != '0) ? pend_q[r] - CW'(1) : '0;
      if (issue && dlong && dwreg && (drn == AW'(r))) pend_d[r] = LAT_M1;
    end
    busy_d = (busy_q != '0) ? busy_q - CW'(1) : '0;
    if (issue && dlong) busy_d = LAT_M1;
  end

  // ID/EX next state: issued work or a bubble that keeps the old data.
  always_comb begin
    xvalid_d = 1'b0;
    xwreg_d  = 1'b0;
    xm2reg_d = 1'b0;
    xlong_d  = 1'b0;
    xa_d     = xa_q;
    xb_d     = xb_q;
    xrn_d    = xrn_q;
    if (issue) begin
      xvalid_d = 1'b1;
      xwreg_d  = dwreg;
      xm2reg_d = dm2reg;
      xlong_d  = dlong;
      xa_d     = a_val;
      xb_d     = b_val;
      xrn_d    = drn;
    end
  end

  // State registers; reset clears both ID/EX and any pending countdowns.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_q   <= '0;
      busy_q   <= '0;
      xvalid_q <= 1'b0;
      xwreg_q  <= 1'b0;
      xm2reg_q <= 1'b0;
      xlong_q  <= 1'b0;
      xa_q     <= '0;
      xb_q     <= '0;
      xrn_q    <= '0;
    end else begin
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      xvalid_q <= xvalid_d;
      xwreg_q  <= xwreg_d;
      xm2reg_q <= xm2reg_d;
      xlong_q  <= xlong_d;
      xa_q     <= xa_d;
      xb_q     <= xb_d;
      xrn_q    <= xrn_d;
    end
  end

  assign xvalid = xvalid_q;
  assign xwreg  = xwreg_q;
  assign xm2reg = xm2reg_q;
  assign xlong  = xlong_q;
  assign xa     = xa_q;
  assign xb     = xb_q;
  assign xrn    = xrn_q;

endmodule

// File: doc/pipeid_sb.md
# pipeid_sb

Parametrised operand/issue stage for the pipelined CPU, successor to the fixed 32-bit ID stage. It:
- resolves source operands from the register file or from E/M/W bypasses;
- detects load-use and long-latency (multiply/divide) hazards with a per-register countdown scoreboard;
- drives the PC/IR write enable;
- registers the issued operands into an internal ID/EX stage, inserting a bubble on stall.

Decode stays in the control unit; this block consumes decoded fields.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREG, 32, architectural registers; AW = $clog2(NREG); register 0 hard-wired zero
- LONG_LAT, 4, cycles from long-op issue to its W-stage writeback (min 2)
- WBYP, 1, 1 = bypass W-stage write data to operands (regfile written on clock edge); 0 = regfile written on ~clock, no W bypass

Ports:
- clock  in  1  system clock; one clock domain; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- dvalid  in  1  instruction present in D
- rs, rt  in  AW  source register numbers
- use_rs, use_rt  in  1  source actually read
- drn  in  AW  destination register
- dwreg, dm2reg, dlong  in  1  writes reg / is load / is long-latency op
- qa, qb  in  XLEN  regfile read data for rs, rt
- ern, mrn, wrn  in  AW  destinations in E, M, W
- ewreg, em2reg, mwreg, mm2reg, wwreg  in  1  stage control bits
- ealu, malu, mmo, wdi  in  XLEN  E ALU, M ALU, M memory, W write data
- wpcir  out  1  PC/IR write enable; 0 = stall
- rsrtequ  out  1  resolved A == resolved B (branch compare, combinational)
- xvalid, xwreg, xm2reg, xlong  out  1  registered issue controls
- xa, xb  out  XLEN  registered resolved operands
- xrn  out  AW  registered destination

## Operation
Operand resolution, per source, in priority order:
- Source number 0 → 0.
- ewreg & ~em2reg & ern==src → ealu.
- mwreg & mrn==src → mm2reg ? mmo : malu.
- WBYP & wwreg & wrn==src → wdi.
- Otherwise qa/qb.

Stall (wpcir=0) when dvalid and any of:
- Load-use: used source equals ern, ewreg, em2reg, ern≠0.
- Scoreboard: used source has pend[src]≠0, or dwreg with pend[drn]≠0 (WAW).
- Structural: dlong and busy≠0.

Scoreboard and busy counter:
- pend[r], width $clog2(LONG_LAT+1), one per register r≠0.
- busy, same width, for the non-pipelined long unit.

Issue (dvalid & wpcir):
- Load ID/EX registers with the resolved operands and controls.
- If dlong & dwreg & drn≠0: set pend[drn] = LONG_LAT-1.
- If dlong: set busy = LONG_LAT-1.

Stall or ~dvalid:
- Load a bubble: xvalid=xwreg=xm2reg=xlong=0.
- xa, xb, xrn hold their previous values.

Every cycle:
- Each nonzero pend and busy decrements by 1, saturating at 0.
- A set on issue overrides the decrement for that entry.
- The long result appears on wrn/wwreg/wdi in the cycle its pend reaches 0. The W bypass or regfile then supplies it, so the first unstalled reader sees the correct value.

## Timing
- Reset (resetn=0, async): xvalid, xwreg, xm2reg, xlong = 0; xa, xb = 0; xrn = 0; all pend and busy = 0. wpcir evaluates combinationally (1 if no hazard).
- Issue latency: one clock, D inputs → x* outputs.
- wpcir and rsrtequ are combinational from current inputs and state, with no register.
- Load-use hazard: exactly one stall cycle.
- Long-op dependant: stalls LAT-1 cycles after the producer issues.
- Simultaneous issue of a long op and decrement of a different entry: both apply.
- Reset asserted mid-countdown clears all pending state. Any in-flight long result is then the caller's responsibility to discard.

## Structure
- Shared package: AW derivation, counter-width function, forward-select encoding (FWD_QA, FWD_EALU, FWD_MALU, FWD_MMO, FWD_WDI).
- One sub-module, pipeid_sb_fwd: single-operand forwarding mux plus hazard match. Instantiated twice, for rs and rt.
- The scoreboard counter array stays in the top level.

## Test plan
- Reset: hold resetn=0 with nonzero inputs → all x* = 0; wpcir=1 with no hazard; release → first issue appears on the next edge.
- Forward priority: rs=5 with ern=5, ewreg=1, ealu=0x11 and mrn=5, mwreg=1, malu=0x22 → xa=0x11. Drop ewreg → xa=0x22. Set mm2reg=1, mmo=0x33 → xa=0x33.
- Load-use: ern=7, ewreg=1, em2reg=1, rt=7, use_rt=1 → wpcir=0 for one cycle, bubble issued (xvalid=0); next cycle (load now in M) → xb=mmo.
- Long op, LONG_LAT=4: issue dlong to r9; dependant on r9 follows immediately → 3 stall cycles. On release, wrn=9, wwreg=1, wdi=0xABCD → xa=0xABCD.
- Structural and register 0: two back-to-back dlong ops → second stalls until busy=0. rs=0 with ern=0, ewreg=1 → no stall, xa=0.
- Branch compare: resolved A=B=0x5 via mixed bypass paths → rsrtequ=1. Flip one bit → rsrtequ=0.
